usart_rx_frame_ctrl: RTL and testbench
======================================

// Module: usart_rx_frame_ctrl
// PURPOSE
//  USART receive frame sequencer. Detects the start bit on the synchronized RXD line and sequences the start, data, parity and stop bits.
//  Assembles the LSB-first data frame and drives the external parity checker (frame, size, mode, enable); compares its result with the received parity bit.
//  Presents the completed frame in a holding register with frame, parity and overrun status.
//  Sits between the baud generator (16x sample tick) and the register/bus interface.
// PARAMETERS
//  OVERSAMPLE   16   sample ticks per bit; power of two
//  MID_SAMPLE   7    sample index (0-based) that is the bit centre
// PORTS
//  i_clk            in   1  system clock
//  i_rst_n          in   1  asynchronous active-low reset
//  i_sample_tick    in   1  1-cycle strobe, OVERSAMPLE x baud
//  i_rxd            in   1  receive line, already synchronized to i_clk; idle high
//  i_rx_en          in   1  receiver enable (RXEN)
//  i_frame_size     in   3  000=5,001=6,010=7,011=8,111=9 data bits; other codes treated as 8
//  i_parity_mode    in   2  UPM[1:0]: 0x=none, 10=even, 11=odd
//  i_stop_bits      in   1  0=one stop bit, 1=two stop bits
//  i_rd_strobe      in   1  1-cycle read of holding register; clears o_rx_complete and error flags
//  i_parity_check   in   1  expected parity bit from the parity checker (combinational)
//  o_check_frame    out  9  data shift register to the checker
//  o_check_size     out  3  i_frame_size latched at start bit
//  o_check_mode     out  1  UPM0 latched at start bit
//  o_check_en       out  1  1-cycle strobe at parity-bit centre
//  o_rx_data        out  9  holding register, zero-extended above the frame size
//  o_rx_complete    out  1  holding register full (RXC)
//  o_frame_err      out  1  first stop bit sampled low (FE)
//  o_parity_err     out  1  received parity bit != i_parity_check (UPE)
//  o_data_overrun   out  1  frame lost because the holding register was full (DOR)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; sample counter=0; shift register=0.
//  FSM: IDLE->START on i_rxd=0 with i_sample_tick and i_rx_en; sample counter cleared.
//   START: at MID_SAMPLE, rxd=1 -> false start, go to IDLE; rxd=0 -> DATA. Thereafter each bit centre is every OVERSAMPLE ticks.
//   DATA: shift the sampled bit in at position bit_idx (LSB first). After size bits: -> PARITY if UPM1=1, else -> STOP1.
//   PARITY: at the centre, assert o_check_en for 1 cycle; latch the parity error (rx bit ^ i_parity_check) the same cycle.
//   STOP1: sample the bit; 0 -> frame error. If i_stop_bits=1 -> STOP2, else -> DONE. STOP2 is sampled but never flags an error.
//   DONE (1 cycle): if o_rx_complete=0 or i_rd_strobe=1 the same cycle, load o_rx_data, FE and UPE, and set o_rx_complete; otherwise set o_data_overrun and discard the frame.
//   DONE then returns to IDLE. A new start bit is accepted from the next tick.
//  Latency: o_rx_complete rises 1 clk after the centre of the last stop bit.
//  i_rd_strobe clears o_rx_complete, o_frame_err, o_parity_err and o_data_overrun. DONE load has priority over a same-cycle clear.
//  i_rx_en deasserted in any state: -> IDLE next clk; the partial frame is dropped; the holding register is kept.
//  i_frame_size and i_parity_mode changes mid-frame are ignored; both are latched at start.
//  Asynchronous reset mid-frame: immediate return to reset values.
//  Sample counter wraps modulo OVERSAMPLE; bit_idx is 4 bits and saturates at 8.
// CONFIGURATION
//  USART_RX_MAJORITY_EN defined: each bit value is the 2-of-3 majority of samples MID_SAMPLE-1, MID_SAMPLE and MID_SAMPLE+1.
//   The decision is made at MID_SAMPLE+1, so check/complete timing shifts +1 tick.
//  Not defined: single sample at MID_SAMPLE.
// STRUCTURE
//  usart_pkg: frame-size codes (FS_5..FS_9), UPM codes, FSM state localparams, function size_to_bits().
//  Sub-module usart_rx_bit_sampler: sample counter, bit-centre strobe, optional majority vote.
//  The FSM, shift register and holding register stay in this module.
// TESTING
//  8N1, byte 0xA5, no read pending -> o_rx_data=0x0A5, o_rx_complete=1, FE=0, UPE=0, 1 clk after stop centre.
//  7E1, data 0x15 with parity bit 0 (wrong: three ones -> expected 1) -> o_check_en pulses once; UPE=1; o_check_size=010.
//  9O2, data 0x1FF with parity bit 0 -> UPE=0. Second stop bit low -> FE=0.
//  8N1, stop bit low -> FE=1. Low glitch of 3 ticks on idle line -> false start; no o_rx_complete.
//  Two 8N1 frames 0x11, 0x22 with no read -> o_rx_data=0x11, DOR=1. i_rd_strobe in the DONE cycle -> 0x22 loaded, DOR=0.
//  i_rx_en dropped during DATA bit 3 -> IDLE, no complete. With USART_RX_MAJORITY_EN, a 1-tick spike at a bit centre does not flip the bit.

Source files
------------

// File: rtl/usart_pkg.sv
// Shared definitions for the USART receive path: frame-size and parity-mode
// codes, receive FSM states and the frame-size decoder.
package usart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int MID_SAMPLE_DEF = 7;

    localparam logic [2:0] FS_5 = 3'b000;
    localparam logic [2:0] FS_6 = 3'b001;
    localparam logic [2:0] FS_7 = 3'b010;
    localparam logic [2:0] FS_8 = 3'b011;
    localparam logic [2:0] FS_9 = 3'b111;

    localparam logic [1:0] UPM_EVEN = 2'b10;
    localparam logic [1:0] UPM_ODD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_DONE
    } rx_state_e;

    // Reserved frame-size codes decode as 8 data bits.
    function automatic logic [3:0] size_to_bits(input logic [2:0] fs);
        case (fs)
            FS_5:    return 4'd5;
            FS_6:    return 4'd6;
            FS_7:    return 4'd7;
            FS_8:    return 4'd8;
            FS_9:    return 4'd9;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/usart_rx_bit_sampler.sv
// Oversampling counter and bit-centre strobe for the USART receiver.
// USART_RX_MAJORITY_EN selects a 2-of-3 vote around the centre sample.
module usart_rx_bit_sampler
    import usart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int MID_SAMPLE = MID_SAMPLE_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_clear,
    input  logic i_rxd,
    output logic o_strobe,
    output logic o_bit
);

    localparam int CW = $clog2(OVERSAMPLE);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] idx_d;

    // cnt_q holds the index of the last tick; the clearing tick is index 0.
    assign idx_d = cnt_q + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_clear) begin
            cnt_q <= '0;
        end else if (i_tick) begin
            cnt_q <= idx_d;
        end
    end

`ifdef USART_RX_MAJORITY_EN
    logic [1:0] win_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            win_q <= '0;
        end else if (i_tick && !i_clear) begin
            if (idx_d == CW'(MID_SAMPLE - 1)) win_q[0] <= i_rxd;
            if (idx_d == CW'(MID_SAMPLE))     win_q[1] <= i_rxd;
        end
    end

    assign o_strobe = i_tick && !i_clear && (idx_d == CW'(MID_SAMPLE + 1));
    assign o_bit    = (win_q[0] & win_q[1]) | (win_q[0] & i_rxd) | (win_q[1] & i_rxd);
`else
    assign o_strobe = i_tick && !i_clear && (idx_d == CW'(MID_SAMPLE));
    assign o_bit    = i_rxd;
`endif

endmodule

// File: rtl/usart_rx_frame_ctrl.sv
// USART receive frame sequencer: start/data/parity/stop sequencing, parity
// checker handshake and holding register. USART_RX_MAJORITY_EN enables voting.
module usart_rx_frame_ctrl
    import usart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int MID_SAMPLE = MID_SAMPLE_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sample_tick,
    input  logic       i_rxd,
    input  logic       i_rx_en,
    input  logic [2:0] i_frame_size,
    input  logic [1:0] i_parity_mode,
    input  logic       i_stop_bits,
    input  logic       i_rd_strobe,
    input  logic       i_parity_check,
    output logic [8:0] o_check_frame,
    output logic [2:0] o_check_size,
    output logic       o_check_mode,
    output logic       o_check_en,
    output logic [8:0] o_rx_data,
    output logic       o_rx_complete,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_data_overrun
);

    rx_state_e  state_q;
    logic [8:0] shift_q;
    logic [3:0] bit_idx_q;
    logic [2:0] size_q;
    logic       mode_q;
    logic       par_en_q;
    logic       par_bit_q;
    logic       check_en_q;
    logic       fe_pend_q;
    logic       pe_pend_q;
    logic [8:0] rx_data_q;
    logic       rxc_q;
    logic       fe_q;
    logic       pe_q;
    logic       dor_q;

    logic       start_d;
    logic       bit_stb;
    logic       bit_val;
    logic [3:0] nbits_d;

    assign start_d = (state_q == ST_IDLE) && i_sample_tick && !i_rxd && i_rx_en;
    assign nbits_d = size_to_bits(size_q);

    usart_rx_bit_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .MID_SAMPLE (MID_SAMPLE)
    ) u_sampler (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_tick   (i_sample_tick),
        .i_clear  (start_d),
        .i_rxd    (i_rxd),
        .o_strobe (bit_stb),
        .o_bit    (bit_val)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            size_q     <= '0;
            mode_q     <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            check_en_q <= 1'b0;
            fe_pend_q  <= 1'b0;
            pe_pend_q  <= 1'b0;
            rx_data_q  <= '0;
            rxc_q      <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            dor_q      <= 1'b0;
        end else begin
            check_en_q <= 1'b0;
            // The checker answers combinationally while o_check_en is high.
            if (check_en_q) pe_pend_q <= par_bit_q ^ i_parity_check;
            if (i_rd_strobe) begin
                rxc_q <= 1'b0;
                fe_q  <= 1'b0;
                pe_q  <= 1'b0;
                dor_q <= 1'b0;
            end
            if (!i_rx_en) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_d) begin
                            state_q   <= ST_START;
                            shift_q   <= '0;
                            bit_idx_q <= '0;
                            size_q    <= i_frame_size;
                            mode_q    <= i_parity_mode[0];
                            par_en_q  <= (i_parity_mode == UPM_EVEN) || (i_parity_mode == UPM_ODD);
                            fe_pend_q <= 1'b0;
                            pe_pend_q <= 1'b0;
                        end
                    end
                    ST_START: begin
                        if (bit_stb) state_q <= bit_val ? ST_IDLE : ST_DATA;
                    end
                    ST_DATA: begin
                        if (bit_stb) begin
                            shift_q[bit_idx_q] <= bit_val;
                            if (bit_idx_q == nbits_d - 4'd1)
                                state_q <= par_en_q ? ST_PARITY : ST_STOP1;
                            if (bit_idx_q != 4'd8) bit_idx_q <= bit_idx_q + 4'd1;
                        end
                    end
                    ST_PARITY: begin
                        if (bit_stb) begin
                            par_bit_q  <= bit_val;
                            check_en_q <= 1'b1;
                            state_q    <= ST_STOP1;
                        end
                    end
                    ST_STOP1: begin
                        if (bit_stb) begin
                            fe_pend_q <= !bit_val;
                            state_q   <= i_stop_bits ? ST_STOP2 : ST_DONE;
                        end
                    end
                    ST_STOP2: begin
                        if (bit_stb) state_q <= ST_DONE;
                    end
                    ST_DONE: begin
                        // A read in this cycle frees the register for the new frame.
                        if (!rxc_q || i_rd_strobe) begin
                            rx_data_q <= shift_q;
                            fe_q      <= fe_pend_q;
                            pe_q      <= pe_pend_q;
                            rxc_q     <= 1'b1;
                            dor_q     <= 1'b0;
                        end else begin
                            dor_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_check_frame  = shift_q;
    assign o_check_size   = size_q;
    assign o_check_mode   = mode_q;
    assign o_check_en     = check_en_q;
    assign o_rx_data      = rx_data_q;
    assign o_rx_complete  = rxc_q;
    assign o_frame_err    = fe_q;
    assign o_parity_err   = pe_q;
    assign o_data_overrun = dor_q;

endmodule

// File: tb/tb_usart_rx_frame_ctrl.sv
// Scoreboard bench for usart_rx_frame_ctrl: directed frames on a 4-clock tick
// grid, expected holding-register contents queued, compared by a monitor.
module tb_usart_rx_frame_ctrl;

`ifdef USART_RX_MAJORITY_EN
    localparam int STB = 8;
`else
    localparam int STB = 7;
`endif

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       rxd;
    logic       rx_en;
    logic [2:0] frame_size;
    logic [1:0] parity_mode;
    logic       stop_bits;
    logic       rd;
    logic       parity_check;
    logic [8:0] check_frame;
    logic [2:0] check_size;
    logic       check_mode;
    logic       check_en;
    logic [8:0] rx_data;
    logic       rx_complete;
    logic       frame_err;
    logic       parity_err;
    logic       data_overrun;

    usart_rx_frame_ctrl dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_sample_tick  (tick),
        .i_rxd          (rxd),
        .i_rx_en        (rx_en),
        .i_frame_size   (frame_size),
        .i_parity_mode  (parity_mode),
        .i_stop_bits    (stop_bits),
        .i_rd_strobe    (rd),
        .i_parity_check (parity_check),
        .o_check_frame  (check_frame),
        .o_check_size   (check_size),
        .o_check_mode   (check_mode),
        .o_check_en     (check_en),
        .o_rx_data      (rx_data),
        .o_rx_complete  (rx_complete),
        .o_frame_err    (frame_err),
        .o_parity_err   (parity_err),
        .o_data_overrun (data_overrun)
    );

    typedef struct {
        logic [8:0] data;
        logic       fe;
        logic       pe;
        logic       dor;
        int         nchk;
        logic [2:0] csize;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int size_bits(input logic [2:0] fs);
        case (fs)
            3'b000:  return 5;
            3'b001:  return 6;
            3'b010:  return 7;
            3'b111:  return 9;
            default: return 8;
        endcase
    endfunction

    // External parity checker: even parity of the frame, inverted for odd mode.
    always_comb begin
        logic [8:0] m;
        m = 9'h000;
        for (int i = 0; i < size_bits(check_size); i++) m[i] = check_frame[i];
        parity_check = (^m) ^ check_mode;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: any change of the holding register state while full is an event.
    logic [12:0] prev_snap;
    int          chk_cnt;
    logic [2:0]  chk_size_seen;
    always @(negedge clk) begin : monitor
        logic [12:0] snap;
        exp_t e;
        if (!rst_n) begin
            prev_snap = '0;
            chk_cnt   = 0;
            chk_size_seen = '0;
        end else begin
            if (check_en) begin
                chk_cnt++;
                chk_size_seen = check_size;
            end
            snap = {rx_complete, data_overrun, frame_err, parity_err, rx_data};
            if (snap != prev_snap && rx_complete) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: data 0x%0h dor %0b, expected no event", rx_data, data_overrun);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.data));
                    check("frame_err", 32'(frame_err), 32'(e.fe));
                    check("parity_err", 32'(parity_err), 32'(e.pe));
                    check("data_overrun", 32'(data_overrun), 32'(e.dor));
                    check("check_en_pulses", 32'(chk_cnt), 32'(e.nchk));
                    if (e.nchk > 0) check("check_size", 32'(chk_size_seen), 32'(e.csize));
                    $display("frame event: data 0x%03h fe %0b pe %0b dor %0b chk %0d",
                             rx_data, frame_err, parity_err, data_overrun, chk_cnt);
                end
                chk_cnt = 0;
            end
            prev_snap = snap;
        end
    end

    task automatic push(input logic [8:0] d, input logic fe, input logic pe, input logic dor,
                        input int nchk, input logic [2:0] cs);
        exp_t e;
        e.data = d; e.fe = fe; e.pe = pe; e.dor = dor; e.nchk = nchk; e.csize = cs;
        exp_q.push_back(e);
    endtask

    task automatic do_tick(input logic rd_after);
        @(negedge clk) tick = 1'b1;
        @(negedge clk) begin tick = 1'b0; rd = rd_after; end
        @(negedge clk) rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [8:0] data, input logic [2:0] fs, input logic [1:0] upm,
                              input logic two_stop, input logic par_bit, input logic stop1_v,
                              input logic stop2_v, input logic rd_in_done, input int abort_bit,
                              input int spike_bit);
        logic bits [16];
        int   n;
        int   first_stop;
        n = 0;
        bits[n++] = 1'b0;
        for (int i = 0; i < size_bits(fs); i++) bits[n++] = data[i];
        if (upm[1]) bits[n++] = par_bit;
        first_stop = n;
        bits[n++] = stop1_v;
        if (two_stop) bits[n++] = stop2_v;
        frame_size = fs; parity_mode = upm; stop_bits = two_stop;
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < 16; k++) begin
                if (b == abort_bit && k == 4) begin
                    rx_en = 1'b0;
                    rxd   = 1'b1;
                    repeat (20) do_tick(1'b0);
                    rx_en = 1'b1;
                    return;
                end
                if (b == 1 && k == 0) begin
                    frame_size  = ~fs;
                    parity_mode = ~upm;
                end
                if (b >= first_stop && k > STB) rxd = 1'b1;
                else rxd = bits[b] ^ (b == spike_bit && k == 7);
                do_tick(rd_in_done && b == n - 1 && k == STB);
            end
        end
        rxd = 1'b1;
        repeat (4) do_tick(1'b0);
    endtask

    task automatic read_hold();
        @(negedge clk) rd = 1'b1;
        @(negedge clk) rd = 1'b0;
        check("rxc_after_read", 32'(rx_complete), 32'd0);
        check("fe_after_read", 32'(frame_err), 32'd0);
        check("dor_after_read", 32'(data_overrun), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; tick = 1'b0; rxd = 1'b1; rx_en = 1'b0;
        frame_size = 3'b011; parity_mode = 2'b00; stop_bits = 1'b0; rd = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rxc", 32'(rx_complete), 32'd0);
        check("reset_fe", 32'(frame_err), 32'd0);
        check("reset_pe", 32'(parity_err), 32'd0);
        check("reset_dor", 32'(data_overrun), 32'd0);
        check("reset_check_en", 32'(check_en), 32'd0);
        check("reset_check_frame", 32'(check_frame), 32'd0);
        check("reset_check_size", 32'(check_size), 32'd0);
        check("reset_check_mode", 32'(check_mode), 32'd0);
        rst_n = 1'b1;
        rx_en = 1'b1;
        repeat (2) do_tick(1'b0);

        // 8N1 0xA5
        push(9'h0A5, 0, 0, 0, 0, 3'b000);
        send_frame(9'h0A5, 3'b011, 2'b00, 0, 0, 1, 1, 0, -1, -1);
        read_hold();
        // 7E1 0x15, parity bit 0 but even parity needs 1
        push(9'h015, 0, 1, 0, 1, 3'b010);
        send_frame(9'h015, 3'b010, 2'b10, 0, 0, 1, 1, 0, -1, -1);
        read_hold();
        // 9O2 0x1FF, parity 0 correct, second stop low ignored
        push(9'h1FF, 0, 0, 0, 1, 3'b111);
        send_frame(9'h1FF, 3'b111, 2'b11, 1, 0, 1, 0, 0, -1, -1);
        read_hold();
        // 8N1 with stop bit low
        push(9'h03C, 1, 0, 0, 0, 3'b000);
        send_frame(9'h03C, 3'b011, 2'b00, 0, 0, 0, 1, 0, -1, -1);
        read_hold();
        // 3-tick low glitch: false start
        rxd = 1'b0;
        repeat (3) do_tick(1'b0);
        rxd = 1'b1;
        repeat (20) do_tick(1'b0);
        check("false_start_rxc", 32'(rx_complete), 32'd0);
        // overrun, then a read in the DONE cycle
        push(9'h011, 0, 0, 0, 0, 3'b000);
        send_frame(9'h011, 3'b011, 2'b00, 0, 0, 1, 1, 0, -1, -1);
        push(9'h011, 0, 0, 1, 0, 3'b000);
        send_frame(9'h022, 3'b011, 2'b00, 0, 0, 1, 1, 0, -1, -1);
        push(9'h022, 0, 0, 0, 0, 3'b000);
        send_frame(9'h022, 3'b011, 2'b00, 0, 0, 1, 1, 1, -1, -1);
        read_hold();
        // receiver disabled during data bit 3, then a clean frame
        send_frame(9'h05A, 3'b011, 2'b00, 0, 0, 1, 1, 0, 4, -1);
        check("abort_rxc", 32'(rx_complete), 32'd0);
        push(9'h0C3, 0, 0, 0, 0, 3'b000);
        send_frame(9'h0C3, 3'b011, 2'b00, 0, 0, 1, 1, 0, -1, -1);
        read_hold();
`ifdef USART_RX_MAJORITY_EN
        // 1-tick high spike at the centre of data bit 2 is voted out
        push(9'h000, 0, 0, 0, 0, 3'b000);
        send_frame(9'h000, 3'b011, 2'b00, 0, 0, 1, 1, 0, -1, 3);
        read_hold();
`endif
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
